// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: MIPS opcode/funct fields,
// ALU operation codes, FSM states and the decoder result bundle.
package alu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_LW   = 4'b0010;
  localparam logic [3:0] ALU_SW   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_ANDI = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_BEQ  = 4'b1000;
  localparam logic [3:0] ALU_JAL  = 4'b1001;
  localparam logic [3:0] ALU_JR   = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_SUB  = 4'b1100;
  localparam logic [3:0] ALU_OR   = 4'b1101;
  localparam logic [3:0] ALU_MULT = 4'b1110;
  localparam logic [3:0] ALU_DIV  = 4'b1111;

  typedef enum logic {ST_IDLE, ST_MULTI} state_e;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       illegal;
    logic       is_mult;
    logic       is_div;
  } dec_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct lookup; unknown combinations decode to ADD
// with the illegal flag raised.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec = '{alu_op: ALU_ADD, illegal: 1'b0, is_mult: 1'b0, is_div: 1'b0};
    case (opcode)
      OP_ADDI: dec.alu_op = ALU_ADD;
      OP_LW:   dec.alu_op = ALU_LW;
      OP_SW:   dec.alu_op = ALU_SW;
      OP_ANDI: dec.alu_op = ALU_ANDI;
      OP_BEQ:  dec.alu_op = ALU_BEQ;
      OP_JAL:  dec.alu_op = ALU_JAL;
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  dec.alu_op = ALU_ADD;
          FN_SLL:  dec.alu_op = ALU_SLL;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_NOR:  dec.alu_op = ALU_NOR;
          FN_JR:   dec.alu_op = ALU_JR;
          FN_SLT:  dec.alu_op = ALU_SLT;
          FN_SUB:  dec.alu_op = ALU_SUB;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_MULT: begin
            dec.alu_op  = ALU_MULT;
            dec.is_mult = 1'b1;
          end
          FN_DIV: begin
            dec.alu_op = ALU_DIV;
            dec.is_div = 1'b1;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_control_seq.sv
// Registered, handshaked ALU control: decode into an output register and
// hold issue while a mult/div occupies the muldiv unit.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned CTRL_W   = 4,
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              stall,
  input  logic              flush,
  output logic              in_ready,
  output logic              out_valid,
  output logic [CTRL_W-1:0] alu_op,
  output logic              illegal,
  output logic              busy,
  output logic              done
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT);

  dec_t             w_dec;
  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_done, w_done_nxt;
  logic             r_out_valid, r_illegal;
  logic [3:0]       r_alu_op;
  logic             w_busy, w_accept;

  alu_ctrl_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .dec    (w_dec)
  );

  assign w_busy    = (r_state == ST_MULTI);
  assign in_ready  = !w_busy && (!r_out_valid || !stall);
  assign w_accept  = in_valid && in_ready && !flush;

  assign out_valid = r_out_valid;
  assign alu_op    = CTRL_W'(r_alu_op);
  assign illegal   = r_illegal;
  assign busy      = w_busy;
  assign done      = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Counter runs regardless of stall; the done pulse is issued on the edge
  // that observes zero, i.e. LAT edges after the accepting edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && (w_dec.is_mult || w_dec.is_div)) begin
            w_state_nxt = ST_MULTI;
            w_cnt_nxt   = w_dec.is_mult ? CNT_W'(MULT_LAT - 1) : CNT_W'(DIV_LAT - 1);
          end
        end
        ST_MULTI: begin
          if (r_cnt == '0) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_alu_op    <= '0;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_alu_op    <= w_dec.alu_op;
      r_illegal   <= w_dec.illegal;
    end else if (!stall) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Randomised scoreboard bench for alu_control_seq with a cycle-level
// reference model of ready/busy/done and a table-driven decode reference.
module tb_alu_control_seq;

  localparam int unsigned MLAT = 4;
  localparam int unsigned DLAT = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       in_ready, out_valid, illegal, busy, done;
  logic [3:0] alu_op;

  alu_control_seq #(.CTRL_W(4), .MULT_LAT(MLAT), .DIV_LAT(DLAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .opcode    (opcode),
    .funct     (funct),
    .stall     (stall),
    .flush     (flush),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .alu_op    (alu_op),
    .illegal   (illegal),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] op;
    bit         ill;
  } exp_t;
  exp_t sb[$];

  bit m_ov, m_busy, m_done;
  int m_rem;

  logic [5:0] I_OP   [6]  = '{6'b001000, 6'b100011, 6'b101011, 6'b001100, 6'b000100, 6'b000011};
  logic [3:0] I_CODE [6]  = '{4'b0000, 4'b0010, 4'b0011, 4'b0110, 4'b1000, 4'b1001};
  logic [5:0] R_FN   [10] = '{6'b100000, 6'b000000, 6'b100100, 6'b100111, 6'b001000,
                              6'b101010, 6'b100010, 6'b100101, 6'b011000, 6'b011010};
  logic [3:0] R_CODE [10] = '{4'b0000, 4'b0100, 4'b0101, 4'b0111, 4'b1010,
                              4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};

  function automatic void ref_dec(input logic [5:0] op, input logic [5:0] fn,
                                  output exp_t e, output int lat);
    e.op = 4'b0000;
    e.ill = 1'b1;
    lat = 0;
    if (op == 6'b000000) begin
      foreach (R_FN[i]) begin
        if (R_FN[i] == fn) begin
          e.op = R_CODE[i];
          e.ill = 1'b0;
          lat = (i == 8) ? int'(MLAT) : (i == 9) ? int'(DLAT) : 0;
        end
      end
    end else begin
      foreach (I_OP[i]) begin
        if (I_OP[i] == op) begin
          e.op = I_CODE[i];
          e.ill = 1'b0;
        end
      end
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && !stall) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("alu_op", int'(alu_op), int'(e.op));
        chk("illegal", int'(illegal), int'(e.ill));
      end
    end
  end

  task automatic model_reset();
    m_ov = 1'b0;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_rem = 0;
    sb.delete();
  endtask

  task automatic cycle(input bit v, input logic [5:0] op, input logic [5:0] fn,
                       input bit st, input bit fl, output bit acc);
    exp_t e;
    int   lat;
    bit   rdy;
    @(posedge clk);
    #1;
    in_valid = v;
    opcode = op;
    funct = fn;
    stall = st;
    flush = fl;
    @(negedge clk);
    #1;
    rdy = !m_busy && (!m_ov || !st);
    chk("in_ready", int'(in_ready), int'(rdy));
    chk("out_valid", int'(out_valid), int'(m_ov));
    chk("busy", int'(busy), int'(m_busy));
    chk("done", int'(done), int'(m_done));
    acc = v && rdy && !fl;
    ref_dec(op, fn, e, lat);
    if (fl) begin
      // A stalled output that is flushed never transfers downstream.
      if (m_ov && st && sb.size() > 0) void'(sb.pop_front());
      m_ov = 1'b0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_rem = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
      if (acc) begin
        sb.push_back(e);
        m_ov = 1'b1;
        if (lat > 0) begin
          m_busy = 1'b1;
          m_rem = lat;
        end
      end else if (!st) begin
        m_ov = 1'b0;
      end
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] fn);
    bit acc;
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      cycle(1'b1, op, fn, 1'b0, 1'b0, acc);
      n++;
    end
    if (!acc) chk("issue_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    logic [5:0] op, fn;
    model_reset();

    #22;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_alu_op", int'(alu_op), 0);
    chk("rst_illegal", int'(illegal), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk);
    #3 reset = 1'b0;

    foreach (I_OP[i]) issue(I_OP[i], 6'($urandom));
    foreach (R_FN[i]) issue(6'b000000, R_FN[i]);
    idle(2);

    issue(6'b000000, 6'b111111);
    issue(6'b111111, 6'b000000);
    idle(2);

    issue(6'b100011, 6'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 6'b000000, 6'b100000, 1'b1, 1'b0, acc);
      chk("hold_alu_op", int'(alu_op), 2);
    end
    cycle(1'b1, 6'b000000, 6'b100000, 1'b0, 1'b0, acc);
    chk("release_accept", int'(acc), 1);
    idle(2);

    issue(6'b000000, 6'b011000);
    issue(6'b000000, 6'b011000);
    idle(6);

    issue(6'b000000, 6'b011010);
    idle(9);
    cycle(1'b1, 6'b000000, 6'b100000, 1'b0, 1'b1, acc);
    idle(40);

    issue(6'b000000, 6'b011010);
    idle(4);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("areset_out_valid", int'(out_valid), 0);
    chk("areset_alu_op", int'(alu_op), 0);
    chk("areset_illegal", int'(illegal), 0);
    chk("areset_busy", int'(busy), 0);
    chk("areset_done", int'(done), 0);
    model_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    issue(6'b001000, 6'd0);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          op = I_OP[$urandom_range(0, 5)];
          fn = 6'($urandom);
        end else begin
          op = 6'b000000;
          fn = R_FN[$urandom_range(0, 9)];
        end
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      cycle($urandom_range(0, 3) != 0, op, fn,
            $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0, acc);
    end

    idle(40);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
